// File: rtl/rca_pkg.sv
// Constants and types shared between the 100-bit ripple-carry adder, its operand loader and their benches.
package rca_pkg;

  localparam int RCA_WIDTH = 100;
  localparam int RCA_CHUNK = 20;

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } loader_state_e;

endpackage

// File: rtl/rca_operand_loader.sv
// Assembles the adder operand pair from a narrow LSB-first chunk stream and
// holds it, together with cin, under a valid/ready handshake.
//
// state   | meaning
// FILL    | collecting chunks; beat selects the chunk written next
// PRESENT | complete pair on a/b/cin, waiting for out_ready
module rca_operand_loader
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CHUNK = RCA_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_a,
  input  logic [CHUNK-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin
);

  localparam int NBEATS = WIDTH / CHUNK;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  loader_state_e     state;
  logic [BW-1:0]     beat;
  logic              in_hs;
  logic              out_hs;
  logic [NBEATS-1:0] chunk_we;

  assign out_valid = (state == PRESENT);

  // While presenting, a new beat 0 may only enter in the cycle the pair leaves.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && !in_flush) begin
      in_ready = (state == FILL) ? 1'b1 : out_ready;
    end
  end

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    chunk_we = '0;
    for (int i = 0; i < NBEATS; i++) begin
      chunk_we[i] = in_hs && (beat == BW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      beat  <= '0;
    end else if (in_flush) begin
      state <= FILL;
      beat  <= '0;
    end else if (in_hs) begin
      if (beat == LAST_BEAT) begin
        state <= PRESENT;
        beat  <= '0;
      end else begin
        state <= FILL;
        beat  <= beat + 1'b1;
      end
    end else if (out_hs) begin
      state <= FILL;
    end
  end

  // Operand registers are never cleared by flush; unwritten chunks stay stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      cin <= 1'b0;
    end else begin
      for (int i = 0; i < NBEATS; i++) begin
        if (chunk_we[i]) begin
          a[i*CHUNK +: CHUNK] <= in_a;
          b[i*CHUNK +: CHUNK] <= in_b;
        end
      end
      if (chunk_we[0]) begin
        cin <= in_cin;
      end
    end
  end

endmodule

// File: tb/tb_rca_operand_loader.sv
// Self-checking bench for rca_operand_loader: directed scenarios plus a
// randomized run against a queue-based model of chunk assembly.
module tb_rca_operand_loader;

  localparam int W = 100;
  localparam int C = 20;
  localparam int N = W / C;

  typedef struct packed {
    logic [C-1:0] ca;
    logic [C-1:0] cb;
    logic         ci;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [C-1:0] in_a;
  logic [C-1:0] in_b;
  logic         in_cin;
  logic         in_flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rca_operand_loader #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .cin       (cin)
  );

  // Operand value built from chunk list: chunk i is worth 2^(C*i).
  function automatic logic [W-1:0] pack_field(input beat_t q[$], input bit sel_b);
    logic [W-1:0] r;
    logic [W-1:0] part;
    r = '0;
    for (int i = 0; i < q.size(); i++) begin
      part = W'(sel_b ? q[i].cb : q[i].ca);
      r = r | (part << (C * i));
    end
    return r;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t r;
    r.ca = C'($urandom);
    r.cb = C'($urandom);
    r.ci = 1'($urandom);
    return r;
  endfunction

  // Offers one beat, waits (bounded) until accepted, returns at posedge+1.
  task automatic send_beat(input beat_t bt);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = bt.ca;
    in_b     = bt.cb;
    in_cin   = bt.ci;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_a      = '1;
    in_b      = '1;
    in_cin    = 1'b1;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors += 5;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (a !== '0) begin miscompares++; $display("FAIL reset_a: got %h want 0", a); end
    if (b !== '0) begin miscompares++; $display("FAIL reset_b: got %h want 0", b); end
    if (cin !== 1'b0) begin miscompares++; $display("FAIL reset_cin: got %b want 0", cin); end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    beat_t q[$];
    beat_t bt;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bt.ca = C'(i + 1);
      bt.cb = '1;
      bt.ci = (i == 0);
      q.push_back(bt);
      send_beat(bt);
      if (i == N - 2) begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_early_valid: got %b want 0", out_valid); end
      end
    end
    vectors += 6;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL load_out_valid: got %b want 1", out_valid); end
    if (a[19:0] !== 20'h00001) begin miscompares++; $display("FAIL load_a_lo: got %h want 00001", a[19:0]); end
    if (a[99:80] !== 20'h00005) begin miscompares++; $display("FAIL load_a_hi: got %h want 00005", a[99:80]); end
    if (a !== pack_field(q, 0)) begin miscompares++; $display("FAIL load_a: got %h want %h", a, pack_field(q, 0)); end
    if (b !== {W{1'b1}}) begin miscompares++; $display("FAIL load_b: got %h want all ones", b); end
    if (cin !== 1'b1) begin miscompares++; $display("FAIL load_cin: got %b want 1", cin); end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_consumed: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    beat_t q[$];
    beat_t f[$];
    beat_t bt;
    logic [W-1:0] ea, eb;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bt = rnd_beat();
      q.push_back(bt);
      send_beat(bt);
    end
    ea = pack_field(q, 0);
    eb = pack_field(q, 1);
    bt = rnd_beat();
    in_valid = 1'b1;
    in_a = bt.ca;
    in_b = bt.cb;
    in_cin = bt.ci;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors += 5;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      if (a !== ea) begin miscompares++; $display("FAIL bp_a: got %h want %h", a, ea); end
      if (b !== eb) begin miscompares++; $display("FAIL bp_b: got %h want %h", b, eb); end
      if (cin !== q[0].ci) begin miscompares++; $display("FAIL bp_cin: got %b want %b", cin, q[0].ci); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: out_valid=%b want 0", out_valid); end
    for (int i = 0; i < N; i++) begin
      bt = rnd_beat();
      f.push_back(bt);
      send_beat(bt);
    end
    vectors += 2;
    if (a !== pack_field(f, 0)) begin miscompares++; $display("FAIL bp_next_a: got %h want %h", a, pack_field(f, 0)); end
    if (cin !== f[0].ci) begin miscompares++; $display("FAIL bp_next_cin: got %b want %b", cin, f[0].ci); end
    drain();
  endtask

  task automatic test_back_to_back();
    beat_t bs[2*N];
    beat_t p1[$];
    beat_t p2[$];
    for (int i = 0; i < 2*N; i++) bs[i] = rnd_beat();
    bs[0].ci = 1'b1;
    bs[N].ci = 1'b0;
    for (int i = 0; i < N; i++) begin
      p1.push_back(bs[i]);
      p2.push_back(bs[N+i]);
    end
    out_ready = 1'b1;
    for (int k = 0; k <= 2*N; k++) begin
      if (k < 2*N) begin
        in_valid = 1'b1;
        in_a = bs[k].ca;
        in_b = bs[k].cb;
        in_cin = bs[k].ci;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 2*N) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready k=%0d: got %b want 1", k, in_ready); end
      end
      vectors++;
      if (out_valid !== (k == N || k == 2*N)) begin
        miscompares++;
        $display("FAIL b2b_out_valid k=%0d: got %b want %b", k, out_valid, (k == N || k == 2*N));
      end
      if (k == N) begin
        vectors += 3;
        if (a !== pack_field(p1, 0)) begin miscompares++; $display("FAIL b2b_p1_a: got %h want %h", a, pack_field(p1, 0)); end
        if (b !== pack_field(p1, 1)) begin miscompares++; $display("FAIL b2b_p1_b: got %h want %h", b, pack_field(p1, 1)); end
        if (cin !== 1'b1) begin miscompares++; $display("FAIL b2b_p1_cin: got %b want 1", cin); end
      end
      if (k == 2*N) begin
        vectors += 3;
        if (a !== pack_field(p2, 0)) begin miscompares++; $display("FAIL b2b_p2_a: got %h want %h", a, pack_field(p2, 0)); end
        if (b !== pack_field(p2, 1)) begin miscompares++; $display("FAIL b2b_p2_b: got %h want %h", b, pack_field(p2, 1)); end
        if (cin !== 1'b0) begin miscompares++; $display("FAIL b2b_p2_cin: got %b want 0", cin); end
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    beat_t f[$];
    beat_t bt;
    logic [W-1:0] ea;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(rnd_beat());
    bt = rnd_beat();
    in_flush = 1'b1;
    in_valid = 1'b1;
    in_a = bt.ca;
    in_b = bt.cb;
    in_cin = bt.ci;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    in_flush  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bt = rnd_beat();
      f.push_back(bt);
      send_beat(bt);
    end
    ea = pack_field(f, 0);
    vectors += 4;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_fresh_valid: got %b want 1", out_valid); end
    if (a !== ea) begin miscompares++; $display("FAIL flush_fresh_a: got %h want %h", a, ea); end
    if (b !== pack_field(f, 1)) begin miscompares++; $display("FAIL flush_fresh_b: got %h want %h", b, pack_field(f, 1)); end
    if (cin !== f[0].ci) begin miscompares++; $display("FAIL flush_fresh_cin: got %b want %b", cin, f[0].ci); end
    in_flush = 1'b1;
    @(posedge clk);
    #1;
    in_flush = 1'b0;
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_present: out_valid=%b want 0", out_valid); end
    if (a !== ea) begin miscompares++; $display("FAIL flush_keeps_a: got %h want %h", a, ea); end
  endtask

  task automatic test_reset_midfill();
    beat_t f[$];
    beat_t bt;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send_beat(rnd_beat());
    reset = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    if (a !== '0) begin miscompares++; $display("FAIL rmid_a: got %h want 0", a); end
    if (b !== '0) begin miscompares++; $display("FAIL rmid_b: got %h want 0", b); end
    if (cin !== 1'b0) begin miscompares++; $display("FAIL rmid_cin: got %b want 0", cin); end
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      bt = rnd_beat();
      f.push_back(bt);
      send_beat(bt);
    end
    vectors += 3;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_valid: got %b want 1", out_valid); end
    if (a !== pack_field(f, 0)) begin miscompares++; $display("FAIL rmid_next_a: got %h want %h", a, pack_field(f, 0)); end
    if (b !== pack_field(f, 1)) begin miscompares++; $display("FAIL rmid_next_b: got %h want %h", b, pack_field(f, 1)); end
    drain();
  endtask

  task automatic test_cin_sampling();
    beat_t bt;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bt = rnd_beat();
      bt.ci = (i != 0);
      send_beat(bt);
    end
    vectors += 2;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL cin_valid: got %b want 1", out_valid); end
    if (cin !== 1'b0) begin miscompares++; $display("FAIL cin_sample: got %b want 0", cin); end
    drain();
  endtask

  task automatic test_random();
    beat_t pend[$];
    beat_t held[$];
    beat_t cur;
    logic  holding;
    logic  exp_ready;
    holding = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      cur       = rnd_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      in_flush  = ($urandom_range(0, 24) == 0);
      in_a      = cur.ca;
      in_b      = cur.cb;
      in_cin    = cur.ci;
      @(negedge clk);
      exp_ready = !in_flush && (!holding || out_ready);
      vectors += 2;
      if (in_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ready); end
      if (out_valid !== holding) begin miscompares++; $display("FAIL rnd_out_valid cyc=%0d: got %b want %b", cyc, out_valid, holding); end
      if (holding) begin
        vectors += 3;
        if (a !== pack_field(held, 0)) begin miscompares++; $display("FAIL rnd_a cyc=%0d: got %h want %h", cyc, a, pack_field(held, 0)); end
        if (b !== pack_field(held, 1)) begin miscompares++; $display("FAIL rnd_b cyc=%0d: got %h want %h", cyc, b, pack_field(held, 1)); end
        if (cin !== held[0].ci) begin miscompares++; $display("FAIL rnd_cin cyc=%0d: got %b want %b", cyc, cin, held[0].ci); end
      end
      if (in_flush) begin
        pend.delete();
        holding = 1'b0;
      end else begin
        if (holding && out_ready) holding = 1'b0;
        if (in_valid && exp_ready) begin
          pend.push_back(cur);
          if (pend.size() == N) begin
            held = pend;
            holding = 1'b1;
            pend.delete();
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_flush  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_load();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midfill();
    test_cin_sampling();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
